// File: rtl/shared_pkg.sv
// Shared definitions for the APB master arbiter.
//   state_e        : one-hot APB sequencer state (IDLE / SETUP / ACCESS)
//   DATA_WIDTH     : default APB data width
//   ADDR_WIDTH     : default APB address width
//   NUM_REQ        : default number of requesters
//   TIMEOUT_CYCLES : default ACCESS wait-state budget before abort
//   req_idx_t      : requester index type for the default NUM_REQ
package shared_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int ADDR_WIDTH     = 32;
  localparam int NUM_REQ        = 4;
  localparam int TIMEOUT_CYCLES = 16;

  typedef logic [$clog2(NUM_REQ)-1:0] req_idx_t;

  typedef enum logic [2:0] {
    IDLE   = 3'b001,
    SETUP  = 3'b010,
    ACCESS = 3'b100
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req        in  NUM_REQ  request vector
//   last_grant in  IDXW     index granted most recently; search starts one above
//   en         in  1        arbitration enable; no grant when low
//   gnt        out NUM_REQ  one-hot grant (all zero when nothing wins)
//   gnt_idx    out IDXW     binary index of the winner (last_grant when none)
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDXW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDXW-1:0]    last_grant,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDXW-1:0]    gnt_idx
);

  logic            found;
  logic [IDXW-1:0] idx;

  // Walk last_grant+1 .. last_grant+NUM_REQ (mod NUM_REQ); first hit wins.
  // The previous winner is visited last, which gives the rotation.
  always_comb begin
    gnt     = '0;
    gnt_idx = last_grant;
    found   = 1'b0;
    idx     = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = IDXW'((int'(last_grant) + i) % NUM_REQ);
      if (en && !found && req[idx]) begin
        found       = 1'b1;
        gnt[idx]    = 1'b1;
        gnt_idx     = idx;
      end
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter + APB master sequencer sharing one APB slave port.
//   PCLK, PRESETn       clock / async active-low reset
//   req_valid/write     per-requester request strobe and direction
//   req_addr/req_wdata  packed per-requester address and write data
//   req_ready           one-hot accept (combinational)
//   rsp_valid           one-hot one-cycle completion pulse
//   rsp_rdata/rsp_err   read data and error, valid with rsp_valid
//   PSEL..PWDATA        APB master outputs
//   PRDATA/PREADY/PSLVERR APB slave inputs
module apb_master_arbiter #(
  parameter int DATA_WIDTH     = shared_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH     = shared_pkg::ADDR_WIDTH,
  parameter int NUM_REQ        = shared_pkg::NUM_REQ,
  parameter int TIMEOUT_CYCLES = shared_pkg::TIMEOUT_CYCLES
) (
  input  logic                          PCLK,
  input  logic                          PRESETn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic                          PSEL,
  output logic                          PENABLE,
  output logic                          PWRITE,
  output logic [ADDR_WIDTH-1:0]         PADDR,
  output logic [DATA_WIDTH-1:0]         PWDATA,
  input  logic [DATA_WIDTH-1:0]         PRDATA,
  input  logic                          PREADY,
  input  logic                          PSLVERR
);

  import shared_pkg::state_e;
  import shared_pkg::IDLE;
  import shared_pkg::SETUP;
  import shared_pkg::ACCESS;

  localparam int IDXW  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e state, nxt;

  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] addr_a;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] wdata_a;

  logic [NUM_REQ-1:0]    gnt;
  logic [IDXW-1:0]       gnt_idx, last_grant, cur_idx;
  logic [CNT_W-1:0]      wait_cnt;
  logic                  in_access, timeout, done, acc_en, accept;

  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q, rsp_rdata_q;
  logic                  pwrite_q, rsp_err_q;
  logic [NUM_REQ-1:0]    rsp_valid_q;

  assign addr_a  = req_addr;
  assign wdata_a = req_wdata;

  assign in_access = (state == ACCESS);
  // Abort fires on the ACCESS cycle after TIMEOUT_CYCLES consecutive wait states.
  assign timeout   = in_access & ~PREADY & (wait_cnt == CNT_W'(TIMEOUT_CYCLES));
  assign done      = in_access & (PREADY | timeout);
  // A new winner may be taken from IDLE, or on the completing ACCESS cycle so
  // the next SETUP overlaps the response pulse (2 cycles per transfer).
  assign acc_en    = (state == IDLE) | done;
  assign accept    = |gnt;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDXW(IDXW)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .en         (acc_en),
    .gnt        (gnt),
    .gnt_idx    (gnt_idx)
  );

  assign req_ready = gnt;

  // Decoded straight from the state register so an async reset drops them at once.
  assign PSEL    = (state == SETUP) | (state == ACCESS);
  assign PENABLE = in_access;
  assign PADDR   = paddr_q;
  assign PWRITE  = pwrite_q;
  assign PWDATA  = pwdata_q;

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (accept) nxt = SETUP;
      SETUP:   nxt = ACCESS;
      ACCESS:  if (done) nxt = accept ? SETUP : IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state       <= IDLE;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      cur_idx     <= '0;
      last_grant  <= IDXW'(NUM_REQ - 1);
      wait_cnt    <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state <= nxt;

      if (accept) begin
        paddr_q    <= addr_a[gnt_idx];
        pwrite_q   <= req_write[gnt_idx];
        pwdata_q   <= req_write[gnt_idx] ? wdata_a[gnt_idx] : '0;
        cur_idx    <= gnt_idx;
        last_grant <= gnt_idx;
      end

      if (in_access & ~PREADY & ~timeout) wait_cnt <= wait_cnt + 1'b1;
      else                                wait_cnt <= '0;

      // Response uses the outgoing transfer's cur_idx/pwrite_q; a same-cycle
      // accept only updates them at this edge.
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      if (done) begin
        rsp_valid_q[cur_idx] <= 1'b1;
        rsp_err_q            <= ~PREADY | PSLVERR;
        rsp_rdata_q          <= (PREADY & ~pwrite_q) ? PRDATA : '0;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
module tb_apb_master_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 16;

  logic            PCLK = 1'b0;
  logic            PRESETn;
  logic [N-1:0]    req_valid, req_write, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata, PRDATA, PWDATA;
  logic [AW-1:0]   PADDR;
  logic            rsp_err, PSEL, PENABLE, PWRITE, PREADY, PSLVERR;

  apb_master_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // slave model configuration
  int          cfg_wait = 0;
  logic        cfg_hang = 1'b0;
  logic        cfg_err  = 1'b0;
  logic [31:0] cfg_rdata = 32'h0;
  int          acc_w;

  always @(posedge PCLK or negedge PRESETn)
    if (!PRESETn)                        acc_w <= 0;
    else if (PSEL && PENABLE && !PREADY) acc_w <= acc_w + 1;
    else                                 acc_w <= 0;

  assign PREADY  = PSEL && PENABLE && !cfg_hang && (acc_w >= cfg_wait);
  assign PRDATA  = PREADY ? cfg_rdata : 32'hA5A5_5A5A;
  assign PSLVERR = PREADY && cfg_err;

  // scoreboard + reference round-robin model
  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   acc_idx[$];
  int   acc_cyc[$];
  int   acc_n   = 0;
  int   rsp_n   = 0;
  int   tb_last = N - 1;
  int   cyc     = 0;

  always @(posedge PCLK) cyc <= cyc + 1;

  always @(negedge PCLK) begin
    int   w;
    exp_t e;
    if (PRESETn) begin
      // responses first so a same-cycle grant is not popped by its predecessor
      if (rsp_valid !== '0) begin
        if (sb.size() == 0) check("rsp_spurious", 64'(rsp_valid), 64'(0));
        else begin
          e = sb.pop_front();
          check("rsp_onehot", 64'(rsp_valid), 64'(4'b0001 << e.idx));
          check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
          check("rsp_err", 64'(rsp_err), 64'(e.err));
          rsp_n++;
        end
      end
      if (req_ready !== '0) begin
        w = -1;
        for (int i = 1; i <= N; i++) begin
          int k;
          k = (tb_last + i) % N;
          if (w < 0 && req_valid[k]) w = k;
        end
        if (w < 0) check("grant_spurious", 64'(req_ready), 64'(0));
        else begin
          check("grant", 64'(req_ready), 64'(4'b0001 << w));
          e.idx   = w;
          e.rdata = (req_write[w] || cfg_hang) ? 32'h0 : cfg_rdata;
          e.err   = cfg_hang | cfg_err;
          sb.push_back(e);
          tb_last = w;
          acc_idx.push_back(w);
          acc_cyc.push_back(cyc);
          acc_n++;
        end
      end
    end
  end

  task automatic post(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
    req_valid[i]         = 1'b1;
    req_write[i]         = w;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, rsp_base;
    logic got;
    PRESETn = 1'b0; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge PCLK);
    #2;
    check("rst_psel", 64'(PSEL), 64'(0));
    check("rst_penable", 64'(PENABLE), 64'(0));
    check("rst_paddr", 64'(PADDR), 64'(0));
    check("rst_pwdata", 64'(PWDATA), 64'(0));
    check("rst_pwrite", 64'(PWRITE), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rsp_err", 64'(rsp_err), 64'(0));
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
    check("rst_req_ready", 64'(req_ready), 64'(0));
    @(negedge PCLK); #2 PRESETn = 1'b1;

    // single write, zero wait states
    @(posedge PCLK); #1;
    cfg_wait = 0;
    post(0, 1'b1, 32'h10, 32'hDEAD_BEEF);
    @(negedge PCLK); check("wr_ready", 64'(req_ready), 64'(4'b0001));
    @(posedge PCLK); #1; req_valid[0] = 1'b0;
    @(negedge PCLK);
    check("wr_t1_psel", 64'(PSEL), 64'(1));
    check("wr_t1_penable", 64'(PENABLE), 64'(0));
    check("wr_t1_paddr", 64'(PADDR), 64'(32'h10));
    check("wr_t1_pwrite", 64'(PWRITE), 64'(1));
    check("wr_t1_pwdata", 64'(PWDATA), 64'(32'hDEAD_BEEF));
    @(negedge PCLK);
    check("wr_t2_psel", 64'(PSEL), 64'(1));
    check("wr_t2_penable", 64'(PENABLE), 64'(1));
    @(negedge PCLK);
    check("wr_t3_rsp", 64'(rsp_valid), 64'(4'b0001));
    check("wr_t3_err", 64'(rsp_err), 64'(0));
    check("wr_t3_psel", 64'(PSEL), 64'(0));

    // read from requester 2 with three wait states
    @(posedge PCLK); #1;
    cfg_wait = 3; cfg_rdata = 32'h1234_5678;
    post(2, 1'b0, 32'h24, 32'hFFFF_FFFF);
    @(negedge PCLK); check("rd_ready", 64'(req_ready), 64'(4'b0100));
    @(posedge PCLK); #1; req_valid[2] = 1'b0;
    @(negedge PCLK);
    check("rd_paddr", 64'(PADDR), 64'(32'h24));
    check("rd_pwrite", 64'(PWRITE), 64'(0));
    check("rd_pwdata", 64'(PWDATA), 64'(0));
    check("rd_t1_norsp", 64'(rsp_valid), 64'(0));
    for (int k = 2; k <= 5; k++) begin
      @(negedge PCLK); check("rd_wait_norsp", 64'(rsp_valid), 64'(0));
    end
    @(negedge PCLK);
    check("rd_t6_rsp", 64'(rsp_valid), 64'(4'b0100));
    check("rd_t6_rdata", 64'(rsp_rdata), 64'(32'h1234_5678));
    check("rd_t6_err", 64'(rsp_err), 64'(0));

    // slave error on a write from requester 1
    @(posedge PCLK); #1;
    cfg_wait = 0; cfg_err = 1'b1;
    post(1, 1'b1, 32'h40, 32'hCAFE_0001);
    @(negedge PCLK); check("err_ready", 64'(req_ready), 64'(4'b0010));
    @(posedge PCLK); #1; req_valid[1] = 1'b0;
    repeat (2) @(negedge PCLK);
    @(negedge PCLK);
    check("err_rsp", 64'(rsp_valid), 64'(4'b0010));
    check("err_flag", 64'(rsp_err), 64'(1));
    @(posedge PCLK); #1; cfg_err = 1'b0;

    // timeout: slave never ready
    cfg_hang = 1'b1;
    post(3, 1'b0, 32'h30, 32'h0);
    @(negedge PCLK); check("to_ready", 64'(req_ready), 64'(4'b1000));
    @(posedge PCLK); #1; req_valid[3] = 1'b0;
    for (int k = 1; k <= TO + 2; k++) begin
      @(negedge PCLK); check("to_norsp", 64'(rsp_valid), 64'(0));
    end
    check("to_last_penable", 64'(PENABLE), 64'(1));
    @(negedge PCLK);
    check("to_rsp", 64'(rsp_valid), 64'(4'b1000));
    check("to_err", 64'(rsp_err), 64'(1));
    check("to_rdata", 64'(rsp_rdata), 64'(0));
    check("to_psel_idle", 64'(PSEL), 64'(0));
    @(negedge PCLK);
    check("to_idle_psel", 64'(PSEL), 64'(0));
    check("to_idle_penable", 64'(PENABLE), 64'(0));

    // reset in the middle of ACCESS
    @(posedge PCLK); #1;
    post(0, 1'b0, 32'h50, 32'h0);
    @(negedge PCLK); check("rst_mid_ready", 64'(req_ready), 64'(4'b0001));
    @(posedge PCLK); #1; req_valid[0] = 1'b0;
    repeat (2) @(negedge PCLK);
    check("rst_mid_access", 64'({PSEL, PENABLE}), 64'(2'b11));
    #1 PRESETn = 1'b0;
    sb.delete();
    tb_last = N - 1;
    #1;
    check("rst_mid_psel", 64'(PSEL), 64'(0));
    check("rst_mid_penable", 64'(PENABLE), 64'(0));
    cfg_hang = 1'b0;
    @(posedge PCLK); @(negedge PCLK); #2 PRESETn = 1'b1;
    repeat (3) begin
      @(negedge PCLK); check("rst_mid_norsp", 64'(rsp_valid), 64'(0));
    end

    // fairness: all four held, expect 0,1,2,3,0,1,2,3 at 2 cycles each
    @(posedge PCLK); #1;
    cfg_wait = 0; cfg_rdata = 32'h0BAD_F00D;
    base = acc_n; rsp_base = rsp_n; got = 1'b0;
    for (int i = 0; i < N; i++) post(i, 1'b0, 32'h100 + 32'(i * 4), 32'h0);
    for (int c = 0; c < 40; c++) begin
      @(negedge PCLK); #1;
      if (acc_n >= base + 8) begin got = 1'b1; break; end
    end
    @(posedge PCLK); #1; req_valid = '0;
    check("fair_count", 64'(acc_n - base), 64'(8));
    if (got) begin
      for (int k = 0; k < 8; k++) check("fair_order", 64'(acc_idx[base + k]), 64'(k % N));
      for (int k = 1; k < 8; k++) check("fair_spacing", 64'(acc_cyc[base + k] - acc_cyc[base + k - 1]), 64'(2));
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge PCLK); #1;
      if (sb.size() == 0) break;
    end
    check("fair_drain", 64'(sb.size()), 64'(0));
    check("fair_rsp_count", 64'(rsp_n - rsp_base), 64'(8));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
